control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives every control strobe of the bus-architecture datapath.
- It replaces the hand-sequenced stimulus used in the phase-2 benches.
- It reads the IR value exported by the datapath, runs the fetch sequence, then runs a per-instruction execute sequence.
- One state lasts exactly one clock; outputs are Moore and registered.

Parameters:
BITS, 32, datapath word width (IR width)
OPW, 5, opcode width, IR[BITS-1:BITS-OPW]

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
stop  in  1  request halt at next instruction boundary
IRVal  in  BITS  current IR contents from datapath
PCout, MDRout, RZout, Cout, BAout, Rout, HILOout, INPUTout  out  1 each  bus-drive enables
PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, OUTPUTin, CONin, Rin  out  1 each  register load enables
Gra, Grb, Grc  out  1 each  register-field select for Rout/Rin/BAout
Read, Write  out  1 each  memory read/write strobes
ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC  out  1 each  ALU op selects
MUL, DIV  out  1 each  tied 0 in this revision
run  out  1  1 while executing, 0 in HALT/RESET
illegal  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset (reset=0, any time, mid-instruction included):
  - State goes to S_RESET immediately.
  - All outputs 0, run=0, illegal=0.
- First rising edge after reset deasserts: S_RESET -> T0.
- Outputs are decoded from the registered state (plus latched opcode), so they change only after a clk edge. The datapath samples them on the following edge.
- Strobes not listed for a state are 0.
- Fetch:
  - T0: PCout, MARin, IncPC, RZin.
  - T1: RZout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3: latch opcode = IRVal[31:27] and branch by class.
- Field layout: Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15], C = IR[18:0] sign-extended by the datapath.
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, neg 10000, not 10001, nop 11001, halt 11010.
- ALU register ops (add, sub, shr, shl, ror, rol, and, or):
  - T3: Grb, Rout, RYin.
  - T4: Grc, Rout, op, RZin.
  - T5: RZout, Gra, Rin.
  - then T0.
- Immediate ops (addi -> ADD, andi -> AND, ori -> OR):
  - T3: Grb, Rout, RYin.
  - T4: Cout, op, RZin.
  - T5: RZout, Gra, Rin.
- ldi:
  - T3: Grb, BAout, RYin.
  - T4: Cout, ADD, RZin.
  - T5: RZout, Gra, Rin.
- ld:
  - T3 and T4 as ldi.
  - T5: RZout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
- st:
  - T3 to T5 as ld.
  - T6: Gra, Rout, MDRin (Read=0 so MDR takes the bus).
  - T7: Write.
- neg / not:
  - T3: Grb, Rout, NEGATE or NOT, RZin.
  - T4: RZout, Gra, Rin.
- Instruction lengths, fetch included: nop = 4 cycles (T3 -> T0); ALU and immediate = 6; neg/not = 5; ld and st = 8.
- halt: T3 -> HALT. HALT holds all strobes 0 and run=0 until reset; stop is ignored while in HALT.
- Unsupported opcode: T3 asserts illegal for that cycle, then -> T0 (executes as nop).
- stop is sampled only on the final state of an instruction. If stop=1 there, the next state is HALT instead of T0.
- The opcode latch holds throughout execute; IRVal changes after T3 have no effect.

Decomposition:
- Shared package cpu_ctl_pkg:
  - opcode constants;
  - state encoding (S_RESET, T0..T7, HALT; 4 bits);
  - instruction-class enum (CL_ALU3, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_UNARY, CL_NOP, CL_HALT, CL_ILL).
- Sub-module ctl_decode: combinational, opcode -> class plus a one-hot ALU op select.
- The top-level module holds the state register, opcode latch and output decode.

Test Plan:
- reset=0 for 3 cycles, then release -> all outputs 0 during reset; the next state after release shows PCout=MARin=IncPC=RZin=1, run=1.
- IRVal=0x00800055 (ld r1,0x55(r0)) -> T3..T7 exactly as specified. Read=1 only in T1 and T6; Gra=Rin=1 in T7; next state T0. Total 8 cycles.
- IRVal=0x19890000 (add r3,r1,r2) -> T4 shows Grc, Rout, ADD, RZin; T5 shows Gra, Rin, RZout; instruction takes 6 cycles.
- IRVal=0x11080087 (st 0x87(r1),r2) -> Write=1 only in T7; T6 shows Gra, Rout, MDRin with Read=0.
- IRVal=0xD0000000 (halt) -> enters HALT after T3 and stays for 10+ cycles with run=0. Asserting then deasserting reset restarts at T0.
- IRVal=0xF8000000 (opcode 11111) -> illegal=1 for exactly one cycle at T3, then T0. Also: stop=1 raised during T4 of an add -> HALT follows T5.

Source files
------------

// File: rtl/cpu_ctl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctl_pkg : shared opcodes, state encoding and instruction classes for the
//               hardwired control sequencer.           rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_ctl_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  typedef enum logic [3:0] {
    CL_ALU3,
    CL_IMM,
    CL_LD,
    CL_LDI,
    CL_ST,
    CL_UNARY,
    CL_NOP,
    CL_HALT,
    CL_ILL
  } cls_e;

  // Bit positions of the one-hot ALU select produced by the decoder.
  localparam int ALU_N      = 10;
  localparam int ALU_ADD    = 0;
  localparam int ALU_SUB    = 1;
  localparam int ALU_SHR    = 2;
  localparam int ALU_SHL    = 3;
  localparam int ALU_ROR    = 4;
  localparam int ALU_ROL    = 5;
  localparam int ALU_AND    = 6;
  localparam int ALU_OR     = 7;
  localparam int ALU_NEGATE = 8;
  localparam int ALU_NOT    = 9;

endpackage

`default_nettype wire

// File: rtl/ctl_decode.sv
// ----------------------------------------------------------------------------
// ctl_decode : opcode -> instruction class plus one-hot ALU operation select.
//              rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ctl_decode
  import cpu_ctl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output cls_e             cls,
  output logic [ALU_N-1:0] alu_sel
);

  always_comb begin
    cls     = CL_ILL;
    alu_sel = '0;
    case (opcode)
      OP_LD:   begin cls = CL_LD;    alu_sel[ALU_ADD]    = 1'b1; end
      OP_LDI:  begin cls = CL_LDI;   alu_sel[ALU_ADD]    = 1'b1; end
      OP_ST:   begin cls = CL_ST;    alu_sel[ALU_ADD]    = 1'b1; end
      OP_ADD:  begin cls = CL_ALU3;  alu_sel[ALU_ADD]    = 1'b1; end
      OP_SUB:  begin cls = CL_ALU3;  alu_sel[ALU_SUB]    = 1'b1; end
      OP_SHR:  begin cls = CL_ALU3;  alu_sel[ALU_SHR]    = 1'b1; end
      OP_SHL:  begin cls = CL_ALU3;  alu_sel[ALU_SHL]    = 1'b1; end
      OP_ROR:  begin cls = CL_ALU3;  alu_sel[ALU_ROR]    = 1'b1; end
      OP_ROL:  begin cls = CL_ALU3;  alu_sel[ALU_ROL]    = 1'b1; end
      OP_AND:  begin cls = CL_ALU3;  alu_sel[ALU_AND]    = 1'b1; end
      OP_OR:   begin cls = CL_ALU3;  alu_sel[ALU_OR]     = 1'b1; end
      OP_ADDI: begin cls = CL_IMM;   alu_sel[ALU_ADD]    = 1'b1; end
      OP_ANDI: begin cls = CL_IMM;   alu_sel[ALU_AND]    = 1'b1; end
      OP_ORI:  begin cls = CL_IMM;   alu_sel[ALU_OR]     = 1'b1; end
      OP_NEG:  begin cls = CL_UNARY; alu_sel[ALU_NEGATE] = 1'b1; end
      OP_NOT:  begin cls = CL_UNARY; alu_sel[ALU_NOT]    = 1'b1; end
      OP_NOP:  cls = CL_NOP;
      OP_HALT: cls = CL_HALT;
      default: cls = CL_ILL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer : hardwired fetch/execute control unit for the bus datapath.
//                     rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module control_sequencer
  import cpu_ctl_pkg::*;
#(
  parameter int BITS = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stop,
  input  logic [BITS-1:0] IRVal,
  output logic            PCout,
  output logic            MDRout,
  output logic            RZout,
  output logic            Cout,
  output logic            BAout,
  output logic            Rout,
  output logic            HILOout,
  output logic            INPUTout,
  output logic            PCin,
  output logic            IRin,
  output logic            RYin,
  output logic            RZin,
  output logic            MARin,
  output logic            MDRin,
  output logic            HILOin,
  output logic            OUTPUTin,
  output logic            CONin,
  output logic            Rin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Read,
  output logic            Write,
  output logic            ADD,
  output logic            SUB,
  output logic            SHR,
  output logic            SHL,
  output logic            ROR,
  output logic            ROL,
  output logic            AND,
  output logic            OR,
  output logic            NEGATE,
  output logic            NOT,
  output logic            IncPC,
  output logic            MUL,
  output logic            DIV,
  output logic            run,
  output logic            illegal
);

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic             w_last;
  logic [OPC_W-1:0] r_opcode;
  logic [OPC_W-1:0] w_ir_op;
  logic [OPC_W-1:0] w_opcode;
  cls_e             w_cls;
  logic [ALU_N-1:0] w_alu_sel;
  logic             w_alu_en;
  logic             w_unused_ir;

  assign w_ir_op     = IRVal[BITS-1 -: OPW];
  assign w_unused_ir = ^IRVal[BITS-OPW-1:0];

  // In T3 the IR has just been loaded, so decode it directly; afterwards the
  // latched copy keeps execute immune to later IR changes.
  assign w_opcode = (r_state == S_T3) ? w_ir_op : r_opcode;

  ctl_decode u_decode (
    .opcode  (w_opcode),
    .cls     (w_cls),
    .alu_sel (w_alu_sel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_RESET;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T3) begin
        r_opcode <= w_ir_op;
      end
    end
  end

  always_comb begin
    w_last = 1'b0;
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2:    w_next = S_T3;
      S_T3: begin
        case (w_cls)
          CL_NOP, CL_ILL: w_last = 1'b1;
          CL_HALT:        w_next = S_HALT;
          default:        w_next = S_T4;
        endcase
      end
      S_T4: begin
        if (w_cls == CL_UNARY) w_last = 1'b1;
        else                   w_next = S_T5;
      end
      S_T5: begin
        if (w_cls == CL_ALU3 || w_cls == CL_IMM || w_cls == CL_LDI) w_last = 1'b1;
        else                                                        w_next = S_T6;
      end
      S_T6:    w_next = S_T7;
      S_T7:    w_last = 1'b1;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
    // stop only matters on an instruction boundary
    if (w_last) begin
      w_next = stop ? S_HALT : S_T0;
    end
  end

  always_comb begin
    PCout    = 1'b0;
    MDRout   = 1'b0;
    RZout    = 1'b0;
    Cout     = 1'b0;
    BAout    = 1'b0;
    Rout     = 1'b0;
    HILOout  = 1'b0;
    INPUTout = 1'b0;
    PCin     = 1'b0;
    IRin     = 1'b0;
    RYin     = 1'b0;
    RZin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    HILOin   = 1'b0;
    OUTPUTin = 1'b0;
    CONin    = 1'b0;
    Rin      = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    IncPC    = 1'b0;
    illegal  = 1'b0;
    w_alu_en = 1'b0;
    run      = (r_state != S_RESET) && (r_state != S_HALT);
    case (r_state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1; end
      S_T1: begin RZout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (w_cls)
          CL_ALU3, CL_IMM:      begin Grb = 1'b1; Rout = 1'b1; RYin = 1'b1; end
          CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1; BAout = 1'b1; RYin = 1'b1; end
          CL_UNARY: begin Grb = 1'b1; Rout = 1'b1; RZin = 1'b1; w_alu_en = 1'b1; end
          CL_ILL:   illegal = 1'b1;
          default:  ;
        endcase
      end
      S_T4: begin
        case (w_cls)
          CL_ALU3: begin Grc = 1'b1; Rout = 1'b1; RZin = 1'b1; w_alu_en = 1'b1; end
          CL_IMM, CL_LD, CL_LDI, CL_ST: begin
            Cout = 1'b1; RZin = 1'b1; w_alu_en = 1'b1;
          end
          CL_UNARY: begin RZout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default:  ;
        endcase
      end
      S_T5: begin
        case (w_cls)
          CL_ALU3, CL_IMM, CL_LDI: begin RZout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_LD, CL_ST:            begin RZout = 1'b1; MARin = 1'b1; end
          default:                 ;
        endcase
      end
      S_T6: begin
        case (w_cls)
          CL_LD:   begin Read = 1'b1; MDRin = 1'b1; end
          CL_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (w_cls)
          CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_ST:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ADD    = w_alu_en & w_alu_sel[ALU_ADD];
  assign SUB    = w_alu_en & w_alu_sel[ALU_SUB];
  assign SHR    = w_alu_en & w_alu_sel[ALU_SHR];
  assign SHL    = w_alu_en & w_alu_sel[ALU_SHL];
  assign ROR    = w_alu_en & w_alu_sel[ALU_ROR];
  assign ROL    = w_alu_en & w_alu_sel[ALU_ROL];
  assign AND    = w_alu_en & w_alu_sel[ALU_AND];
  assign OR     = w_alu_en & w_alu_sel[ALU_OR];
  assign NEGATE = w_alu_en & w_alu_sel[ALU_NEGATE];
  assign NOT    = w_alu_en & w_alu_sel[ALU_NOT];

  assign MUL = 1'b0;
  assign DIV = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer : scoreboard bench for control_sequencer.   rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic stop;
  logic [31:0] IRVal;
  logic PCout, MDRout, RZout, Cout, BAout, Rout, HILOout, INPUTout;
  logic PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, OUTPUTin, CONin, Rin;
  logic Gra, Grb, Grc, Read, Write;
  logic ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC, MUL, DIV;
  logic run, illegal;

  always #5 clk = ~clk;

  control_sequencer #(.BITS(32), .OPW(5)) dut (
    .clk(clk), .reset(reset), .stop(stop), .IRVal(IRVal),
    .PCout(PCout), .MDRout(MDRout), .RZout(RZout), .Cout(Cout), .BAout(BAout),
    .Rout(Rout), .HILOout(HILOout), .INPUTout(INPUTout),
    .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
    .MDRin(MDRin), .HILOin(HILOin), .OUTPUTin(OUTPUTin), .CONin(CONin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
    .ADD(ADD), .SUB(SUB), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT), .IncPC(IncPC),
    .MUL(MUL), .DIV(DIV), .run(run), .illegal(illegal)
  );

  // Bit positions inside the 38-bit strobe snapshot.
  localparam int I_PCOUT = 0,  I_MDROUT = 1,  I_RZOUT = 2,  I_COUT = 3,  I_BAOUT = 4;
  localparam int I_ROUT  = 5,  I_PCIN   = 8,  I_IRIN  = 9,  I_RYIN = 10, I_RZIN  = 11;
  localparam int I_MARIN = 12, I_MDRIN  = 13, I_RIN   = 17, I_GRA  = 18, I_GRB   = 19;
  localparam int I_GRC   = 20, I_READ   = 21, I_WRITE = 22, I_ADD  = 23, I_SUB   = 24;
  localparam int I_SHR   = 25, I_SHL    = 26, I_ROR   = 27, I_ROL  = 28, I_AND   = 29;
  localparam int I_OR    = 30, I_NEG    = 31, I_NOT   = 32, I_INCPC = 33;
  localparam int I_RUN   = 36, I_ILL    = 37;

  logic [37:0] act;
  assign act = {illegal, run, DIV, MUL, IncPC, NOT, NEGATE, OR, AND, ROL, ROR, SHL, SHR,
                SUB, ADD, Write, Read, Grc, Grb, Gra, Rin, CONin, OUTPUTin, HILOin,
                MDRin, MARin, RZin, RYin, IRin, PCin, INPUTout, HILOout, Rout, BAout,
                Cout, RZout, MDRout, PCout};

  typedef struct packed {
    logic [37:0] v;
    logic [4:0]  op;
    logic [3:0]  step;
  } exp_t;

  exp_t        sb[$];
  logic [37:0] plan[$];
  bit          plan_halts;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [37:0] m(input int i);
    return 38'd1 << i;
  endfunction

  // ALU strobe an opcode uses in its operate step (0 if none).
  function automatic logic [37:0] alu_of(input logic [4:0] op);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd11: return m(I_ADD);
      5'd4:         return m(I_SUB);
      5'd5:         return m(I_SHR);
      5'd6:         return m(I_SHL);
      5'd7:         return m(I_ROR);
      5'd8:         return m(I_ROL);
      5'd9, 5'd12:  return m(I_AND);
      5'd10, 5'd13: return m(I_OR);
      5'd16:        return m(I_NEG);
      5'd17:        return m(I_NOT);
      default:      return '0;
    endcase
  endfunction

  // Reference model: the full per-cycle strobe list of one instruction.
  task automatic build_plan(input logic [31:0] ir);
    logic [4:0]  op;
    logic [37:0] r;
    logic [37:0] wb;
    op = ir[31:27];
    r  = m(I_RUN);
    wb = r | m(I_RZOUT) | m(I_GRA) | m(I_RIN);
    plan.delete();
    plan_halts = 1'b0;
    plan.push_back(r | m(I_PCOUT) | m(I_MARIN) | m(I_INCPC) | m(I_RZIN));
    plan.push_back(r | m(I_RZOUT) | m(I_PCIN) | m(I_READ) | m(I_MDRIN));
    plan.push_back(r | m(I_MDROUT) | m(I_IRIN));
    if (op >= 5'd3 && op <= 5'd10) begin
      plan.push_back(r | m(I_GRB) | m(I_ROUT) | m(I_RYIN));
      plan.push_back(r | m(I_GRC) | m(I_ROUT) | alu_of(op) | m(I_RZIN));
      plan.push_back(wb);
    end else if (op >= 5'd11 && op <= 5'd13) begin
      plan.push_back(r | m(I_GRB) | m(I_ROUT) | m(I_RYIN));
      plan.push_back(r | m(I_COUT) | alu_of(op) | m(I_RZIN));
      plan.push_back(wb);
    end else if (op <= 5'd2) begin
      plan.push_back(r | m(I_GRB) | m(I_BAOUT) | m(I_RYIN));
      plan.push_back(r | m(I_COUT) | m(I_ADD) | m(I_RZIN));
      if (op == 5'd1) begin
        plan.push_back(wb);
      end else begin
        plan.push_back(r | m(I_RZOUT) | m(I_MARIN));
        if (op == 5'd0) begin
          plan.push_back(r | m(I_READ) | m(I_MDRIN));
          plan.push_back(r | m(I_MDROUT) | m(I_GRA) | m(I_RIN));
        end else begin
          plan.push_back(r | m(I_GRA) | m(I_ROUT) | m(I_MDRIN));
          plan.push_back(r | m(I_WRITE));
        end
      end
    end else if (op == 5'd16 || op == 5'd17) begin
      plan.push_back(r | m(I_GRB) | m(I_ROUT) | alu_of(op) | m(I_RZIN));
      plan.push_back(wb);
    end else if (op == 5'd25) begin
      plan.push_back(r);
    end else if (op == 5'd26) begin
      plan.push_back(r);
      plan_halts = 1'b1;
    end else begin
      plan.push_back(r | m(I_ILL));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (act !== e.v) begin
        n_err++;
        $display("FAIL strobes op=%b step=%0d actual=%h required=%h", e.op, e.step, act, e.v);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [37:0] v, input logic [4:0] op, input int step);
    exp_t e;
    e.v    = v;
    e.op   = op;
    e.step = 4'(step);
    sb.push_back(e);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      stop  = 1'($urandom_range(0, 1));
      IRVal = $urandom;
      push('0, 5'd0, 15);
      next_cycle();
    end
    reset = 1'b1;
    push('0, 5'd0, 15);
    next_cycle();
  endtask

  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) begin
      stop  = 1'($urandom_range(0, 1));
      IRVal = $urandom;
      push('0, 5'd26, 14);
      next_cycle();
    end
  endtask

  // status: 0 = back at T0, 1 = halted, 2 = aborted (caller must reset)
  task automatic run_instr(input logic [31:0] ir, input int stop_from, input int abort_at,
                           output int status);
    int len;
    build_plan(ir);
    len = plan.size();
    status = (plan_halts || (len - 1 >= stop_from)) ? 1 : 0;
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) begin
        status = 2;
        return;
      end
      IRVal = (k == 3) ? ir : $urandom;
      if (k >= stop_from)   stop = 1'b1;
      else if (k < len - 1) stop = ($urandom_range(0, 3) == 0);
      else                  stop = 1'b0;
      push(plan[k], ir[31:27], k);
      next_cycle();
    end
    stop = 1'b0;
  endtask

  task automatic recover(input int status);
    if (status == 1) halt_idle($urandom_range(1, 6));
    if (status != 0) do_reset($urandom_range(1, 3));
  endtask

  localparam logic [4:0] LEGAL [18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
    5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd16, 5'd17, 5'd25, 5'd26};

  initial begin
    int st;
    logic [31:0] ir;
    int abort_at;
    int stop_from;
    reset = 1'b0;
    stop  = 1'b0;
    IRVal = '0;
    next_cycle();
    do_reset(3);
    run_instr(32'h0080_0055, 99, 99, st);  recover(st);   // ld r1,0x55(r0)
    run_instr(32'h1989_0000, 99, 99, st);  recover(st);   // add r3,r1,r2
    run_instr(32'h1108_0087, 99, 99, st);  recover(st);   // st 0x87(r1),r2
    run_instr(32'hF800_0000, 99, 99, st);  recover(st);   // unsupported opcode
    run_instr(32'hC800_0000, 99, 99, st);  recover(st);   // nop
    run_instr(32'h8088_0000, 99, 99, st);  recover(st);   // neg
    run_instr(32'h8888_0000, 99, 99, st);  recover(st);   // not
    run_instr(32'h0888_0005, 99, 99, st);  recover(st);   // ldi
    run_instr(32'h6108_0003, 99, 99, st);  recover(st);   // andi
    run_instr(32'h1989_0000, 4, 99, st);                  // add, stop from T4
    halt_idle(12);
    do_reset(2);
    run_instr(32'hD000_0000, 99, 99, st);                 // halt
    halt_idle(12);
    do_reset(1);
    run_instr(32'h0080_0055, 99, 2, st);                  // reset mid-fetch
    recover(st);
    run_instr(32'h1108_0087, 99, 6, st);                  // reset mid-execute
    recover(st);
    for (int n = 0; n < 200; n++) begin
      ir = $urandom;
      if ($urandom_range(0, 4) != 0) ir[31:27] = LEGAL[$urandom_range(0, 17)];
      abort_at  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : 99;
      stop_from = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 7)) : 99;
      run_instr(ir, stop_from, abort_at, st);
      recover(st);
    end
    next_cycle();
    next_cycle();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    n_err++;
    $display("FAIL watchdog timeout actual=running required=finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
